// File: rtl/io_unit_pkg.sv
// Shared types and default parameter values for io_unit.
// Holds the input-FSM state encoding used by io_unit.
package io_unit_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_IN_W       = 15;
   localparam int DEF_DEB_CYCLES = 1000000;
   localparam int DEF_OUT_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_RELEASE = 2'd3
   } in_state_e;

endpackage

// File: rtl/io_debounce.sv
// Push-button synchroniser and debouncer with one-cycle press/release pulses.
// A button held through reset must be seen released for a full window before presses count.
module io_debounce
   import io_unit_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
)(
   input  logic clock,
   input  logic reset,
   input  logic raw_n,
   output logic level,
   output logic press,
   output logic release_p
);
   localparam int DEB_W = $clog2(DEB_CYCLES);
   localparam logic [DEB_W-1:0] CNT_TC = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             primed_q, primed_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             target_lvl;

   // Until primed, the counter looks for a stable released button instead of a level change.
   always_comb begin
      level_d    = level_q;
      primed_d   = primed_q;
      cnt_d      = cnt_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
      target_lvl = primed_q ? level_q : 1'b0;
      if (sync2_q == target_lvl) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         cnt_d = '0;
         if (primed_q) begin
            level_d = ~level_q;
            press_d = level_q;
            rel_d   = ~level_q;
         end else begin
            primed_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + DEB_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b1;
         primed_q <= 1'b0;
         cnt_q    <= '0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync1_q  <= raw_n;
         sync2_q  <= sync1_q;
         level_q  <= level_d;
         primed_q <= primed_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end

   assign level     = level_q;
   assign press     = press_q;
   assign release_p = rel_q;

endmodule

// File: rtl/io_unit.sv
// Processor IN/OUT unit: debounced confirm-button switch input and output FIFO for the display.
// Define IO_SIGN_EXT_EN to sign-extend the switch word; default build zero-extends.
//
// state      | meaning
// IDLE       | no IN pending
// ARMED      | IN pending, waiting for a button press
// DELIVER    | captured word presented, processor released for one cycle
// RELEASE    | waiting for the button to be let go
module io_unit
   import io_unit_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int IN_W       = DEF_IN_W,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int OUT_DEPTH  = DEF_OUT_DEPTH
)(
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           btn_n,
   input  logic [IN_W-1:0]                sw_in,
   input  logic                           in_req,
   output logic [DATA_W-1:0]              in_data,
   output logic                           in_stall,
   input  logic                           out_req,
   input  logic [DATA_W-1:0]              out_wdata,
   output logic                           out_stall,
   output logic [DATA_W-1:0]              disp_data,
   output logic                           disp_valid,
   input  logic                           disp_next,
   output logic [$clog2(OUT_DEPTH):0]     fifo_count
);
   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic              deb_level, deb_press, deb_release;
   in_state_e         state_q, state_d;
   logic [DATA_W-1:0] in_data_q, in_data_d;
   logic [DATA_W-1:0] sw_ext;

   io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock     (clock),
      .reset     (reset),
      .raw_n     (btn_n),
      .level     (deb_level),
      .press     (deb_press),
      .release_p (deb_release)
   );

`ifdef IO_SIGN_EXT_EN
   assign sw_ext = {{(DATA_W-IN_W){sw_in[IN_W-1]}}, sw_in};
`else
   assign sw_ext = {{(DATA_W-IN_W){1'b0}}, sw_in};
`endif

   always_comb begin
      state_d   = state_q;
      in_data_d = in_data_q;
      unique case (state_q)
         ST_IDLE:    if (in_req) state_d = ST_ARMED;
         ST_ARMED: begin
            if (!in_req) begin
               state_d = ST_IDLE;
            end else if (deb_press) begin
               state_d   = ST_DELIVER;
               in_data_d = sw_ext;
            end
         end
         ST_DELIVER: state_d = ST_RELEASE;
         ST_RELEASE: if (deb_release || deb_level) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign in_stall = in_req && (state_q != ST_DELIVER);
   assign in_data  = in_data_q;

   logic [DATA_W-1:0] mem_q [OUT_DEPTH];
   logic [DATA_W-1:0] mem_d [OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              full, empty, push, pop;

   assign full    = (count_q == CNT_W'(OUT_DEPTH));
   assign empty   = (count_q == '0);
   assign push    = out_req && !full;
   assign pop     = disp_next && !empty;
   assign rd_next = rd_ptr_q + PTR_W'(1);

   // The head register is refilled from memory, or straight from the write port when
   // the pushed word becomes the head in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      disp_d   = disp_q;
      if (push) begin
         mem_d[wr_ptr_q] = out_wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_next;
         if (count_q > CNT_W'(1)) disp_d = mem_q[rd_next];
         else if (push)           disp_d = out_wdata;
      end else if (push && empty) begin
         disp_d = out_wdata;
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         in_data_q <= '0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         disp_q    <= '0;
      end else begin
         state_q   <= state_d;
         in_data_q <= in_data_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         disp_q    <= disp_d;
      end
   end

   assign out_stall  = out_req && full;
   assign disp_data  = disp_q;
   assign disp_valid = !empty;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit with short debounce window and a 4-deep output FIFO.
// Expected switch words and FIFO words are queued at stimulus time and compared on delivery.
module tb_io_unit;
   localparam int DATA_W     = 32;
   localparam int IN_W       = 15;
   localparam int DEB_CYCLES = 4;
   localparam int OUT_DEPTH  = 4;
   localparam int CNT_W      = $clog2(OUT_DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              btn_n = 1'b1;
   logic [IN_W-1:0]   sw_in = '0;
   logic              in_req = 1'b0;
   logic [DATA_W-1:0] in_data;
   logic              in_stall;
   logic              out_req = 1'b0;
   logic [DATA_W-1:0] out_wdata = '0;
   logic              out_stall;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              disp_next = 1'b0;
   logic [CNT_W-1:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] in_exp_q[$];
   logic [DATA_W-1:0] in_got_q[$];
   logic [DATA_W-1:0] fifo_q[$];

   io_unit #(
      .DATA_W(DATA_W), .IN_W(IN_W), .DEB_CYCLES(DEB_CYCLES), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .btn_n(btn_n), .sw_in(sw_in),
      .in_req(in_req), .in_data(in_data), .in_stall(in_stall),
      .out_req(out_req), .out_wdata(out_wdata), .out_stall(out_stall),
      .disp_data(disp_data), .disp_valid(disp_valid), .disp_next(disp_next),
      .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] ext(input logic [IN_W-1:0] v);
`ifdef IO_SIGN_EXT_EN
      return {{(DATA_W-IN_W){v[IN_W-1]}}, v};
`else
      return {{(DATA_W-IN_W){1'b0}}, v};
`endif
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // One cycle: record any word the DUT hands over (in_req high, stall low).
   task automatic watch();
      @(negedge clock);
      if (in_req && !in_stall) in_got_q.push_back(in_data);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_req = 1'b1; out_req = 1'b1; btn_n = 1'b0;
      @(negedge clock);
      checks++; if (in_data !== '0)    begin errors++; $display("FAIL reset_in_data: got %h want 0", in_data); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", disp_valid); end
      checks++; if (disp_data !== '0)  begin errors++; $display("FAIL reset_disp: got %h want 0", disp_data); end
      checks++; if (in_stall !== 1'b1) begin errors++; $display("FAIL reset_in_stall: got %b want 1", in_stall); end
      checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_out_stall: got %b want 0", out_stall); end
      in_req = 1'b0; out_req = 1'b0; btn_n = 1'b1;
      cyc();
      reset = 1'b1;
      repeat (12) cyc();
   endtask

   task automatic test_deliver();
      logic [DATA_W-1:0] exp;
      in_got_q.delete();
      sw_in  = 15'h7FF6;
      in_req = 1'b1;
      in_exp_q.push_back(ext(15'h7FF6));
      for (int i = 0; i < 36; i++) begin
         btn_n = (i >= 2 && i < 12) ? 1'b0 : 1'b1;
         watch();
      end
      checks++;
      if (in_got_q.size() !== in_exp_q.size())
         begin errors++; $display("FAIL deliver_count: got %0d want %0d", in_got_q.size(), in_exp_q.size()); end
      while (in_got_q.size() > 0 && in_exp_q.size() > 0) begin
         exp = in_exp_q.pop_front();
         checks++;
         if (in_got_q[0] !== exp) begin errors++; $display("FAIL deliver_data: got %h want %h", in_got_q[0], exp); end
         void'(in_got_q.pop_front());
      end
      in_exp_q.delete(); in_got_q.delete();
      checks++; if (in_data !== ext(15'h7FF6)) begin errors++; $display("FAIL deliver_hold: got %h want %h", in_data, ext(15'h7FF6)); end
      in_req = 1'b0;
      @(negedge clock);
      checks++; if (in_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", in_stall); end
      cyc();
   endtask

   task automatic test_glitch();
      in_got_q.delete();
      sw_in  = 15'h0001;
      in_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         btn_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         watch();
      end
      btn_n = 1'b1;
      repeat (8) watch();
      checks++;
      if (in_got_q.size() !== 0) begin errors++; $display("FAIL glitch_press: got %0d words want 0", in_got_q.size()); end
      checks++;
      if (in_data !== ext(15'h7FF6)) begin errors++; $display("FAIL glitch_data: got %h want %h", in_data, ext(15'h7FF6)); end
      in_got_q.delete();
      in_req = 1'b0;
      cyc();
   endtask

   task automatic test_fifo_full();
      logic exp_stall;
      for (int i = 1; i <= 5; i++) begin
         out_req = 1'b1; out_wdata = DATA_W'(i);
         @(negedge clock);
         exp_stall = (fifo_q.size() == OUT_DEPTH);
         checks++;
         if (out_stall !== exp_stall) begin errors++; $display("FAIL full_stall%0d: got %b want %b", i, out_stall, exp_stall); end
         if (!exp_stall) fifo_q.push_back(DATA_W'(i));
         cyc();
      end
      out_req = 1'b0;
      @(negedge clock);
      checks++;
      if (fifo_count !== CNT_W'(fifo_q.size())) begin errors++; $display("FAIL full_count: got %0d want %0d", fifo_count, fifo_q.size()); end
      checks++;
      if (disp_data !== fifo_q[0]) begin errors++; $display("FAIL full_head: got %h want %h", disp_data, fifo_q[0]); end
      cyc();
   endtask

   task automatic test_push_pop_full();
      int guard;
      out_req = 1'b1; out_wdata = 32'd6; disp_next = 1'b1;
      @(negedge clock);
      checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL pp_stall: got %b want 1", out_stall); end
      checks++; if (disp_data !== fifo_q[0]) begin errors++; $display("FAIL pp_head: got %h want %h", disp_data, fifo_q[0]); end
      void'(fifo_q.pop_front());
      cyc();
      out_req = 1'b0; disp_next = 1'b0;
      @(negedge clock);
      checks++;
      if (fifo_count !== CNT_W'(fifo_q.size())) begin errors++; $display("FAIL pp_count: got %0d want %0d", fifo_count, fifo_q.size()); end
      checks++; if (disp_data !== fifo_q[0]) begin errors++; $display("FAIL pp_newhead: got %h want %h", disp_data, fifo_q[0]); end
      cyc();
      guard = 0;
      while (fifo_q.size() > 0 && guard < 10) begin
         disp_next = 1'b1;
         @(negedge clock);
         checks++;
         if (disp_data !== fifo_q[0]) begin errors++; $display("FAIL drain: got %h want %h", disp_data, fifo_q[0]); end
         void'(fifo_q.pop_front());
         cyc();
         guard++;
      end
      @(negedge clock);
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", disp_valid); end
      cyc();
      disp_next = 1'b0;
      @(negedge clock);
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL empty_pop: got %0d want 0", fifo_count); end
      cyc();
   endtask

   task automatic test_wrap();
      int pushed = 0, popped = 0, n = 0;
      logic do_push, do_pop, exp_stall;
      logic [DATA_W-1:0] wdata;
      while (popped < 9 && n < 200) begin
         do_push = (pushed < 9) && ($urandom_range(0, 2) != 0);
         do_pop  = (fifo_q.size() != 0) && ($urandom_range(0, 2) == 0);
         wdata   = 32'hC0DE_0000 + DATA_W'(pushed);
         out_req = do_push; out_wdata = wdata; disp_next = do_pop;
         @(negedge clock);
         exp_stall = do_push && (fifo_q.size() == OUT_DEPTH);
         checks++;
         if (out_stall !== exp_stall) begin errors++; $display("FAIL wrap_stall: got %b want %b", out_stall, exp_stall); end
         checks++;
         if (fifo_count !== CNT_W'(fifo_q.size())) begin errors++; $display("FAIL wrap_count: got %0d want %0d", fifo_count, fifo_q.size()); end
         if (do_pop) begin
            checks++;
            if (disp_data !== fifo_q[0]) begin errors++; $display("FAIL wrap_order: got %h want %h", disp_data, fifo_q[0]); end
            void'(fifo_q.pop_front());
            popped++;
         end
         if (do_push && !exp_stall) begin
            fifo_q.push_back(wdata);
            pushed++;
         end
         cyc();
         n++;
      end
      out_req = 1'b0; disp_next = 1'b0;
      checks++;
      if (popped != 9) begin errors++; $display("FAIL wrap_timeout: got %0d words want 9", popped); end
      cyc();
   endtask

   task automatic test_reset_armed();
      logic [DATA_W-1:0] exp;
      for (int i = 0; i < 2; i++) begin
         out_req = 1'b1; out_wdata = 32'hAB00 + DATA_W'(i);
         cyc();
      end
      out_req = 1'b0;
      in_req = 1'b1; sw_in = 15'h0555; btn_n = 1'b0;
      repeat (4) cyc();
      reset = 1'b0;
      #1;
      checks++; if (in_data !== '0)    begin errors++; $display("FAIL rst_in_data: got %h want 0", in_data); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", disp_valid); end
      checks++; if (in_stall !== 1'b1) begin errors++; $display("FAIL rst_in_stall: got %b want 1", in_stall); end
      fifo_q.delete();
      repeat (2) cyc();
      reset = 1'b1;
      in_got_q.delete();
      sw_in = 15'h0123;
      repeat (20) watch();
      checks++;
      if (in_got_q.size() !== 0) begin errors++; $display("FAIL held_press: got %0d words want 0", in_got_q.size()); end
      in_got_q.delete();
      btn_n = 1'b1;
      repeat (10) watch();
      in_exp_q.push_back(ext(15'h0123));
      btn_n = 1'b0;
      repeat (10) watch();
      btn_n = 1'b1;
      repeat (12) watch();
      checks++;
      if (in_got_q.size() !== in_exp_q.size())
         begin errors++; $display("FAIL repress_count: got %0d want %0d", in_got_q.size(), in_exp_q.size()); end
      while (in_got_q.size() > 0 && in_exp_q.size() > 0) begin
         exp = in_exp_q.pop_front();
         checks++;
         if (in_got_q[0] !== exp) begin errors++; $display("FAIL repress_data: got %h want %h", in_got_q[0], exp); end
         void'(in_got_q.pop_front());
      end
      in_req = 1'b0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_deliver();
      test_glitch();
      test_fifo_full();
      test_push_pop_full();
      test_wrap();
      test_reset_armed();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
- DATA_W, 32, processor word width.
- IN_W, 15, switch-input width; IN_W < DATA_W.
- DEB_CYCLES, 1000000, stable-level cycles needed to accept a button change; ≥2.
- OUT_DEPTH, 4, output FIFO depth; power of 2, ≥2.

REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_n  in  1  raw confirm push-button, active-low, asynchronous.
- sw_in  in  IN_W  raw switch word.
- in_req  in  1  processor executing IN.
- in_data  out  DATA_W  extended switch word.
- in_stall  out  1  processor holds PC while high.
- out_req  in  1  processor executing OUT.
- out_wdata  in  DATA_W  word to output.
- out_stall  out  1  processor holds PC while high.
- disp_data  out  DATA_W  FIFO head, for BCD display.
- disp_valid  out  1  FIFO not empty.
- disp_next  in  1  display consumer pop strobe.
- fifo_count  out  $clog2(OUT_DEPTH)+1  occupancy.

Function
REQ-003 btn_n SHALL pass a 2-FF synchroniser, then the debouncer; the debounced level SHALL change only after DEB_CYCLES consecutive cycles of the new synchronised level, and the stability counter SHALL clear on any mismatch.
REQ-004 The debouncer SHALL emit press (one cycle, debounced 1→0) and release (one cycle, 0→1) pulses.
REQ-005 The input FSM SHALL have states IDLE, ARMED, DELIVER and RELEASE.
- IDLE → ARMED on in_req.
- ARMED → DELIVER on press.
- DELIVER → RELEASE unconditionally.
- RELEASE → IDLE on release, or immediately if the button is already debounced-released.
REQ-006 in_stall SHALL be high when in_req=1 and the state is IDLE, ARMED or RELEASE; it SHALL be low in DELIVER and whenever in_req=0.
REQ-007 sw_in SHALL be sampled in the same cycle as press and held in in_data until the next capture; in_data is valid in DELIVER.
REQ-008 A press while not ARMED SHALL be ignored; one press SHALL deliver exactly one word.
REQ-009 If in_req drops in ARMED, the FSM SHALL return to IDLE with no capture.
REQ-010 An out_req with out_stall=0 SHALL push out_wdata in that cycle.
REQ-011 out_stall SHALL equal out_req AND full, using the registered count only; a push is rejected when full even if a pop occurs in the same cycle.
REQ-012 disp_next while disp_valid SHALL pop the head, and disp_data SHALL update the next cycle; disp_next while empty SHALL be ignored.
REQ-013 A simultaneous push and pop when not full and not empty SHALL leave fifo_count unchanged.
REQ-014 Read and write pointers SHALL wrap modulo OUT_DEPTH.
REQ-015 disp_data SHALL be a registered head word with no combinational path from out_wdata.

Reset
REQ-016 On reset low, outputs and state SHALL be forced asynchronously to: in FSM IDLE; debounced level released; counters 0; in_data 0; FIFO empty; fifo_count 0; disp_valid 0; disp_data 0; in_stall and out_stall follow REQ-006 and REQ-011 from the reset state.
REQ-017 Reset mid-DELIVER or mid-debounce SHALL discard the capture; FIFO contents SHALL be lost.
REQ-018 Release of reset SHALL be synchronous to clock.

Configuration
REQ-019 With IO_SIGN_EXT_EN defined, in_data SHALL be sw_in sign-extended from bit IN_W-1.
REQ-020 Without IO_SIGN_EXT_EN, in_data SHALL be sw_in zero-extended.

Structure
REQ-021 Package io_unit_pkg SHALL hold the input-FSM state enum and the default parameter constants.
REQ-022 The debouncer SHALL be sub-module io_debounce (clock, reset, raw_n, level, press, release).

Verification
REQ-023 The bench SHALL cover these scenarios (DEB_CYCLES=4, OUT_DEPTH=4, IN_W=15):
- in_req=1, sw_in=15'h7FF6, btn_n low 10 cycles → exactly one DELIVER cycle; in_data=32'hFFFFFFF6 with IO_SIGN_EXT_EN, 32'h00007FF6 without.
- btn_n toggles every 2 cycles for 20 cycles → no press and in_stall stays high.
- 5 back-to-back out_req with values 1..5, no disp_next → 4 accepted, out_stall=1 on the 5th, fifo_count=4.
- Full FIFO with out_req and disp_next in the same cycle → push rejected, fifo_count=3, disp_data=2.
- Push/pop 9 words through the FIFO → pointers wrap and output order equals input order.
- reset low during ARMED with button held → IDLE and in_data=0; after reset, a held button delivers no word until released and pressed again.
